// File: rtl/port_uart_tx.sv
// UART transmitter output port: 4-entry byte FIFO feeding an 8N1 serializer.
// Status byte reports busy/full/empty/count and a sticky overflow flag.
module port_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic [7:0] status
);

    localparam int unsigned TW = 16;
    localparam int unsigned PW = 2;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      status_q, status_d;
    logic            full, push, pop, bit_end;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push    = wr_en && !full;
    assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

    // Next-state: serializer FSM, FIFO bookkeeping, and registered outputs
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        ovf_d    = ovf_q | (wr_en && full);

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        // tx follows the state being entered so the line changes on the same edge
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        status_d = {1'b0, ovf_d, count_d, (count_d == '0),
                    (count_d == CW'(FIFO_DEPTH)), (state_d != IDLE)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            status_q <= 8'h04;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            status_q <= status_d;
        end
    end

    // Storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx     = tx_q;
    assign status = status_q;

endmodule
